count_mod9_ctrl: RTL and testbench
==================================

Name: count_mod9_ctrl

Overview:
Command front-end that drives the mod-9 counter's mode/load_val interface from raw board push-buttons and switches. It synchronizes and debounces four buttons, then turns press events into a run state. It emits counter commands at a slow tick rate, so a counter clocked on clk advances once per tick. The counter consumes the mode and load_val outputs directly; encodings are STOP=00, INC=01, LOAD=10, DEC2=11.

Parameters:
TICK_DIV, 50000000, clk cycles per tick period; legal range >= 2.
DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples required to accept a level change; legal range >= 2.

Ports:
clk  input  1  system clock
async_reset  input  1  asynchronous, active-high reset
sync_reset  input  1  synchronous active-high clear
btn_inc  input  1  raw async button: run counting up
btn_dec  input  1  raw async button: run counting down by 2
btn_load  input  1  raw async button: load sw_val
btn_stop  input  1  raw async button: stop
sw_val  input  4  raw switch value to load (quasi-static)
mode  output  2  command to counter (00/01/10/11 as above)
load_val  output  4  value to load, always in range 0..8
tick  output  1  one-cycle pulse, once every TICK_DIV cycles
state  output  2  current FSM state: IDLE=00, UP=01, LOAD=10, DOWN=11

Behaviour:
- Reset (async_reset, or sync_reset at the clk edge) sets: mode=00, load_val=0, tick=0, state=IDLE, prescaler=0, all debounce counters and debounced levels=0, event pulses=0. sync_reset clears everything except the 2-flop synchronizers.
- Synchronizer: each btn_* passes through 2 flops before any use.
- Debounce, per button:
  - Counter increments while the synchronized level differs from the debounced level.
  - The counter clears whenever the two levels are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level flips and the counter clears.
  - Net effect: a change is accepted after DEBOUNCE_CYCLES consecutive differing samples. Shorter glitches are discarded.
- Press event: a registered one-cycle pulse in the cycle after the debounced level goes 0->1. Releases generate nothing. Holding a button generates exactly one event.
- Prescaler:
  - Free-running 0..TICK_DIV-1, wraps to 0, runs in every state.
  - Entering UP or DOWN does not restart it.
  - tick is registered and high for exactly one cycle per period, in the cycle after the prescaler equals TICK_DIV-1.
- Event priority when several event pulses coincide: stop > load > dec > inc. Only the highest-priority event is acted on; the rest are dropped.
- FSM (state register updates at the edge ending an event cycle):
  - IDLE: inc->UP, dec->DOWN, load->LOAD, stop->IDLE.
  - UP: dec->DOWN, load->LOAD, stop->IDLE, inc ignored.
  - DOWN: inc->UP, load->LOAD, stop->IDLE, dec ignored.
  - LOAD: lasts exactly one cycle, then unconditionally IDLE. Events arriving during the LOAD cycle are dropped.
- Load capture: at the transition into LOAD, load_val <= (sw_val > 8) ? sw_val-9 : sw_val. Values 9..15 map to 0..6. load_val holds until the next load or reset.
- mode output (registered, aligned with state/tick):
  - 10 during the single LOAD cycle.
  - 01 in UP and 11 in DOWN, only in cycles where tick=1.
  - 00 otherwise.
  - The counter therefore sees exactly one INC or DEC2 command per tick and exactly one LOAD command per load press.
- A state change coinciding with tick uses the new state for mode. Example: the cycle state becomes UP with tick=1 gives mode=01.
- Reset mid-run: mode drops to 00 immediately (async) or at the next edge (sync). A held button must be released and re-pressed to generate a new event.

Test Plan:
(Bench uses TICK_DIV=4, DEBOUNCE_CYCLES=3.)
1. Reset, then hold btn_inc high for 20 cycles. Required: one event; state=01; mode=01 only on tick cycles, one per 4 cycles; other cycles mode=00; no second event while held.
2. btn_dec high-low-high glitch, with each level lasting 2 cycles, then low. Required: no event; state stays 00; mode always 00.
3. In IDLE, sw_val=13, press btn_load. Required: load_val=4; state=10 and mode=10 for exactly 1 cycle, then state=00, mode=00. Repeat with sw_val=8: required load_val=8.
4. In UP, press btn_dec, then btn_inc, then btn_stop. Required: state 01->11->01->00. mode on tick cycles is 11 in DOWN, 01 in UP, and 00 after stop.
5. btn_stop and btn_inc debounced in the same cycle from UP. Required: state=00 (stop wins). btn_load and btn_dec together from IDLE: required state=10.
6. Assert async_reset mid-UP between clk edges. Required: mode=00, tick=0, state=00, load_val=0 immediately. After release, the prescaler restarts from 0, so the first tick arrives 4 cycles later.

Source files
------------

// File: rtl/count_mod9_ctrl.sv
// count_mod9_ctrl
// Command front-end for the mod-9 counter. It turns raw push-buttons and
// switches into the counter's mode/load_val command interface.
//
// Processing chain:
//   - Each button passes through a 2-flop synchronizer.
//   - A per-button debouncer accepts a level change only after
//     DEBOUNCE_CYCLES consecutive differing samples.
//   - A debounced 0->1 transition becomes a one-cycle press event.
//   - Press events drive a small run-state FSM.
//   - A free-running prescaler produces a one-cycle tick every TICK_DIV
//     cycles. UP/DOWN commands are only issued on tick cycles.
//
// Ports:
//   clk          system clock
//   async_reset  asynchronous, active-high reset (clears everything)
//   sync_reset   synchronous, active-high clear (everything except the
//                synchronizer flops)
//   btn_inc      raw button: run counting up
//   btn_dec      raw button: run counting down by 2
//   btn_load     raw button: load sw_val
//   btn_stop     raw button: stop
//   sw_val[3:0]  raw, quasi-static value to load
//   mode[1:0]    counter command: STOP=00, INC=01, LOAD=10, DEC2=11
//   load_val[3:0] value to load, always 0..8
//   tick         one-cycle pulse, once every TICK_DIV cycles
//   state[1:0]   FSM state: IDLE=00, UP=01, LOAD=10, DOWN=11
module count_mod9_ctrl #(
    parameter int TICK_DIV        = 50000000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       async_reset,
    input  logic       sync_reset,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_load,
    input  logic       btn_stop,
    input  logic [3:0] sw_val,
    output logic [1:0] mode,
    output logic [3:0] load_val,
    output logic       tick,
    output logic [1:0] state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    // Bit positions of the buttons inside the packed button vectors.
    localparam int B_INC  = 0;
    localparam int B_DEC  = 1;
    localparam int B_LOAD = 2;
    localparam int B_STOP = 3;

    localparam logic [1:0] M_STOP = 2'b00;
    localparam logic [1:0] M_INC  = 2'b01;
    localparam logic [1:0] M_LOAD = 2'b10;
    localparam logic [1:0] M_DEC2 = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_UP   = 2'b01,
        S_LOAD = 2'b10,
        S_DOWN = 2'b11
    } state_e;

    // Fold a 4-bit switch value into the counter's 0..8 range.
    function automatic logic [3:0] wrap9(input logic [3:0] v);
        return (v > 4'd8) ? (v - 4'd9) : v;
    endfunction

    logic [3:0] btn_raw;
    assign btn_raw = {btn_stop, btn_load, btn_dec, btn_inc};

    // ------------------------------------------------------------------
    // Synchronizer
    // ------------------------------------------------------------------
    logic [3:0] meta_q;
    logic [3:0] sync_q;
    // Marks when sync_q holds real samples rather than reset zeros.
    logic [1:0] sync_vld_q;

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            meta_q     <= '0;
            sync_q     <= '0;
            sync_vld_q <= '0;
        end else begin
            meta_q     <= btn_raw;
            sync_q     <= meta_q;
            sync_vld_q <= {sync_vld_q[0], 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Debounce, press detection
    // ------------------------------------------------------------------
    logic [DW-1:0] deb_cnt_q [4];
    logic [DW-1:0] deb_cnt_d [4];
    logic [3:0]    deb_lvl_q, deb_lvl_d;
    logic [3:0]    arm_q, arm_d;
    logic [3:0]    evt_q, evt_d;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            deb_cnt_d[i] = '0;
            deb_lvl_d[i] = deb_lvl_q[i];
            if (sync_q[i] != deb_lvl_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_lvl_d[i] = ~deb_lvl_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
        // A button is armed once it has been seen released after reset.
        // This keeps a button that is held through a reset from producing
        // an event until it is released and pressed again.
        arm_d = arm_q | ({4{sync_vld_q[1]}} & ~sync_q & ~deb_lvl_q);
        evt_d = deb_lvl_d & ~deb_lvl_q & arm_q;
    end

    // ------------------------------------------------------------------
    // Prescaler, FSM, command outputs
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    state_e        state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [3:0]    load_val_q, load_val_d;

    always_comb begin
        presc_d    = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        tick_d     = (presc_q == PRESC_LAST);
        state_d    = state_q;
        load_val_d = load_val_q;

        // LOAD is a single-cycle state and swallows any events that
        // arrive during it. Otherwise the highest-priority event wins:
        // stop > load > dec > inc. inc in UP and dec in DOWN leave the
        // state unchanged.
        if (state_q == S_LOAD) begin
            state_d = S_IDLE;
        end else if (evt_q[B_STOP]) begin
            state_d = S_IDLE;
        end else if (evt_q[B_LOAD]) begin
            state_d    = S_LOAD;
            load_val_d = wrap9(sw_val);
        end else if (evt_q[B_DEC]) begin
            state_d = S_DOWN;
        end else if (evt_q[B_INC]) begin
            state_d = S_UP;
        end

        // mode is derived from the next state and next tick so that it
        // stays aligned with the registered state/tick outputs.
        mode_d = M_STOP;
        if (state_d == S_LOAD) begin
            mode_d = M_LOAD;
        end else if (tick_d && state_d == S_UP) begin
            mode_d = M_INC;
        end else if (tick_d && state_d == S_DOWN) begin
            mode_d = M_DEC2;
        end
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
            deb_lvl_q  <= '0;
            arm_q      <= '0;
            evt_q      <= '0;
            presc_q    <= '0;
            tick_q     <= 1'b0;
            state_q    <= S_IDLE;
            mode_q     <= M_STOP;
            load_val_q <= '0;
        end else if (sync_reset) begin
            for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
            deb_lvl_q  <= '0;
            arm_q      <= '0;
            evt_q      <= '0;
            presc_q    <= '0;
            tick_q     <= 1'b0;
            state_q    <= S_IDLE;
            mode_q     <= M_STOP;
            load_val_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) deb_cnt_q[i] <= deb_cnt_d[i];
            deb_lvl_q  <= deb_lvl_d;
            arm_q      <= arm_d;
            evt_q      <= evt_d;
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            state_q    <= state_d;
            mode_q     <= mode_d;
            load_val_q <= load_val_d;
        end
    end

    assign mode     = mode_q;
    assign load_val = load_val_q;
    assign tick     = tick_q;
    assign state    = state_q;

endmodule

// File: tb/tb_count_mod9_ctrl.sv
module tb_count_mod9_ctrl;

    localparam int TD  = 4;
    localparam int DEB = 3;

    logic       clk = 1'b0;
    logic       async_reset, sync_reset;
    logic       btn_inc, btn_dec, btn_load, btn_stop;
    logic [3:0] sw_val;
    logic [1:0] mode;
    logic [3:0] load_val;
    logic       tick;
    logic [1:0] state;

    always #5 clk = ~clk;

    count_mod9_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .async_reset(async_reset), .sync_reset(sync_reset),
        .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_load(btn_load),
        .btn_stop(btn_stop), .sw_val(sw_val),
        .mode(mode), .load_val(load_val), .tick(tick), .state(state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model. Button bits: 0=inc 1=dec 2=load 3=stop.
    int         k;          // edges since async reset released
    int         j;          // edges since any reset (prescaler phase)
    logic [3:0] rawq[$];    // last two raw button samples
    logic [3:0] m_lvl, m_arm, m_evt;
    int         m_run[4];   // consecutive samples differing from accepted level
    logic [1:0] m_state, m_mode;
    logic       m_tick;
    logic [3:0] m_lv;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear_all();
        k = 0; j = 0; rawq.delete();
        m_lvl = '0; m_arm = '0; m_evt = '0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        m_state = 2'd0; m_mode = 2'd0; m_tick = 1'b0; m_lv = 4'd0;
    endtask

    task automatic model_edge(input logic ar, input logic sr, input logic [3:0] raw, input logic [3:0] sw);
        logic [3:0] samp, act, lvl_old, arm_old;
        if (ar) begin
            model_clear_all();
            return;
        end
        samp = (k >= 2) ? rawq[0] : 4'b0;
        if (sr) begin
            m_lvl = '0; m_arm = '0; m_evt = '0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            j = 0; m_state = 2'd0; m_mode = 2'd0; m_tick = 1'b0; m_lv = 4'd0;
        end else begin
            act = m_evt;
            if (m_state == 2'd2)  m_state = 2'd0;
            else if (act[3])      m_state = 2'd0;
            else if (act[2]) begin
                m_state = 2'd2;
                m_lv    = 4'(int'(sw) % 9);
            end
            else if (act[1])      m_state = 2'd3;
            else if (act[0])      m_state = 2'd1;
            lvl_old = m_lvl;
            arm_old = m_arm;
            for (int i = 0; i < 4; i++) begin
                m_evt[i] = 1'b0;
                if (samp[i] != m_lvl[i]) m_run[i]++;
                else                     m_run[i] = 0;
                if (m_run[i] == DEB) begin
                    m_lvl[i] = ~m_lvl[i];
                    m_run[i] = 0;
                    m_evt[i] = m_lvl[i] & arm_old[i];
                end
                if (k >= 2 && !samp[i] && !lvl_old[i]) m_arm[i] = 1'b1;
            end
            j++;
            m_tick = (j % TD == 0);
            if (m_state == 2'd2)                  m_mode = 2'd2;
            else if (m_tick && m_state == 2'd1)   m_mode = 2'd1;
            else if (m_tick && m_state == 2'd3)   m_mode = 2'd3;
            else                                  m_mode = 2'd0;
        end
        rawq.push_back(raw);
        if (rawq.size() > 2) void'(rawq.pop_front());
        k++;
    endtask

    task automatic cmp_model(input string tag);
        check({tag, "_state"},    {6'b0, state},    {6'b0, m_state});
        check({tag, "_mode"},     {6'b0, mode},     {6'b0, m_mode});
        check({tag, "_tick"},     {7'b0, tick},     {7'b0, m_tick});
        check({tag, "_load_val"}, {4'b0, load_val}, {4'b0, m_lv});
    endtask

    task automatic step();
        logic       ar, sr;
        logic [3:0] raw, sw;
        ar  = async_reset;
        sr  = sync_reset;
        raw = {btn_stop, btn_load, btn_dec, btn_inc};
        sw  = sw_val;
        @(posedge clk);
        #1;
        model_edge(ar, sr, raw, sw);
        cmp_model("cyc");
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_state(input logic [1:0] exp, input int limit, input string tag);
        int n = 0;
        while (state !== exp && n < limit) begin
            step();
            n++;
        end
        check(tag, {6'b0, state}, {6'b0, exp});
    endtask

    task automatic wait_tick_mode(input logic [1:0] exp, input string tag);
        int n = 0;
        while (tick !== 1'b1 && n < 2 * TD) begin
            step();
            n++;
        end
        check({tag, "_tick"}, {7'b0, tick}, 8'd1);
        check({tag, "_mode"}, {6'b0, mode}, {6'b0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ups, n, first_tick, pick;
        logic [1:0] prev;
        logic [3:0] swr;

        model_clear_all();
        async_reset = 1'b1; sync_reset = 1'b0;
        btn_inc = 0; btn_dec = 0; btn_load = 0; btn_stop = 0;
        sw_val = 4'd0;
        cycles(3);
        check("rst_state", {6'b0, state}, 8'd0);
        check("rst_mode", {6'b0, mode}, 8'd0);
        check("rst_tick", {7'b0, tick}, 8'd0);
        check("rst_load_val", {4'b0, load_val}, 8'd0);
        async_reset = 1'b0;
        cycles(4 + $urandom_range(0, 3));

        // Test 1: hold inc for 20 cycles -> exactly one entry into UP
        btn_inc = 1'b1;
        ups = 0;
        for (int i = 0; i < 20; i++) begin
            prev = state;
            step();
            if (prev != 2'd1 && state == 2'd1) ups++;
        end
        check("t1_state_up", {6'b0, state}, 8'd1);
        check("t1_one_event", 8'(ups), 8'd1);
        btn_inc = 1'b0;
        cycles(6);

        // Test 4: UP -> DOWN -> UP -> IDLE
        btn_dec = 1'b1;
        wait_state(2'd3, 12, "t4_down");
        wait_tick_mode(2'd3, "t4_down_cmd");
        btn_dec = 1'b0;
        cycles(6);
        btn_inc = 1'b1;
        wait_state(2'd1, 12, "t4_up");
        wait_tick_mode(2'd1, "t4_up_cmd");
        btn_inc = 1'b0;
        cycles(6);
        btn_stop = 1'b1;
        wait_state(2'd0, 12, "t4_idle");
        wait_tick_mode(2'd0, "t4_idle_cmd");
        btn_stop = 1'b0;
        cycles(6);

        // Test 2: dec glitch 2 high / 2 low / 2 high -> no event
        btn_dec = 1'b1; cycles(2);
        btn_dec = 1'b0; cycles(2);
        btn_dec = 1'b1; cycles(2);
        btn_dec = 1'b0; cycles(8);
        check("t2_state_idle", {6'b0, state}, 8'd0);

        // Test 3: loads with out-of-range, boundary and random values
        for (int t = 0; t < 3; t++) begin
            swr = (t == 0) ? 4'd13 : (t == 1) ? 4'd8 : 4'($urandom_range(9, 15));
            sw_val = swr;
            btn_load = 1'b1;
            wait_state(2'd2, 12, "t3_load_state");
            check("t3_load_mode", {6'b0, mode}, 8'd2);
            check("t3_load_val", {4'b0, load_val}, (swr > 4'd8) ? 8'(swr) - 8'd9 : 8'(swr));
            step();
            check("t3_after_state", {6'b0, state}, 8'd0);
            check("t3_after_mode", {6'b0, mode}, 8'd0);
            btn_load = 1'b0;
            cycles(6);
        end

        // Test 5a: stop + inc together from UP -> IDLE
        btn_inc = 1'b1;
        wait_state(2'd1, 12, "t5_up");
        btn_inc = 1'b0;
        cycles(6);
        btn_stop = 1'b1; btn_inc = 1'b1;
        wait_state(2'd0, 12, "t5_stop_wins");
        cycles(3);
        check("t5_stop_stays", {6'b0, state}, 8'd0);
        btn_stop = 1'b0; btn_inc = 1'b0;
        cycles(6);

        // Test 5b: load + dec together from IDLE -> LOAD
        sw_val = 4'd5;
        btn_load = 1'b1; btn_dec = 1'b1;
        n = 0;
        while (state === 2'd0 && n < 12) begin
            step();
            n++;
        end
        check("t5_load_wins", {6'b0, state}, 8'd2);
        step();
        check("t5_load_one_cycle", {6'b0, state}, 8'd0);
        btn_load = 1'b0; btn_dec = 1'b0;
        cycles(6);

        // Held button through sync_reset needs release and re-press
        btn_inc = 1'b1;
        wait_state(2'd1, 12, "sr_up");
        cycles($urandom_range(0, 3));
        sync_reset = 1'b1;
        step();
        sync_reset = 1'b0;
        check("sr_state", {6'b0, state}, 8'd0);
        check("sr_mode", {6'b0, mode}, 8'd0);
        cycles(15);
        check("sr_held_no_event", {6'b0, state}, 8'd0);
        btn_inc = 1'b0;
        cycles(6);
        btn_inc = 1'b1;
        wait_state(2'd1, 12, "sr_repress_up");
        btn_inc = 1'b0;
        cycles(6);

        // Test 6: async reset mid-UP, between edges
        cycles($urandom_range(1, 7));
        #2;
        async_reset = 1'b1;
        #1;
        model_clear_all();
        check("t6_async_state", {6'b0, state}, 8'd0);
        check("t6_async_mode", {6'b0, mode}, 8'd0);
        check("t6_async_tick", {7'b0, tick}, 8'd0);
        check("t6_async_load_val", {4'b0, load_val}, 8'd0);
        cycles(2);
        async_reset = 1'b0;
        first_tick = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (first_tick == 0 && tick === 1'b1) first_tick = i;
        end
        check("t6_first_tick", 8'(first_tick), 8'd4);

        // Randomized phase against the reference model
        for (int c = 0; c < 600; c++) begin
            pick = $urandom_range(0, 7);
            if ($urandom_range(0, 3) == 0) begin
                case (pick)
                    0, 1: btn_inc  = ~btn_inc;
                    2, 3: btn_dec  = ~btn_dec;
                    4:    btn_load = ~btn_load;
                    5:    btn_stop = ~btn_stop;
                    default: ;
                endcase
            end
            sw_val = 4'($urandom);
            sync_reset = ($urandom_range(0, 99) == 0);
            step();
        end
        sync_reset = 1'b0;
        btn_inc = 0; btn_dec = 0; btn_load = 0; btn_stop = 0;
        cycles(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
